fx_master: RTL and testbench
============================

FX_MASTER -- requirements
Module: fx_master

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: packet start marker.
REQ-002 SHALL have parameter RD_LAT, default 1: cycles from fx_rd high to fx_q valid, range 1..7.
REQ-003 SHALL have parameter TIMEOUT, default 16'd50000: mid-packet rx idle limit, in clk_sys cycles.
REQ-004 SHALL have port clk_sys, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data, input, 8: command byte stream from the USB side.
REQ-007 SHALL have port rx_vld, input, 1: rx_data valid.
REQ-008 SHALL have port rx_rdy, output, 1: byte accepted when rx_vld and rx_rdy are both high.
REQ-009 SHALL have port tx_data, output, 8: read-back byte stream.
REQ-010 SHALL have port tx_vld, output, 1: tx_data valid.
REQ-011 SHALL have port tx_rdy, input, 1: sink accepts on tx_vld and tx_rdy.
REQ-012 SHALL have port fx_waddr, output, 22: write address.
REQ-013 SHALL have port fx_wr, output, 1: one-cycle write strobe.
REQ-014 SHALL have port fx_data, output, 8: write data.
REQ-015 SHALL have port fx_raddr, output, 22: read address.
REQ-016 SHALL have port fx_rd, output, 1: one-cycle read strobe.
REQ-017 SHALL have port fx_q, input, 8: read data from the fx responder.
REQ-018 SHALL have port err, output, 1: one-cycle pulse on a protocol error.

Function
REQ-019 SHALL parse packets in this order:
- SYNC_BYTE
- CMD: 8'h01 write, 8'h02 read
- A2, A1, A0: address = {A2[5:0], A1, A0}; A2[7:6] ignored
- LEN: byte count N, LEN=0 means N=256
- write only: N data bytes
REQ-020 SHALL implement states IDLE, CMD, ADR2, ADR1, ADR0, LEN, WDATA, RREQ, RWAIT, RSEND.
REQ-021 SHALL hold rx_rdy high in IDLE through WDATA and low in RREQ, RWAIT and RSEND.
REQ-022 In IDLE SHALL discard any accepted byte not equal to SYNC_BYTE, without raising err.
REQ-023 On a CMD byte other than 01/02 SHALL pulse err and return to IDLE.
REQ-024 In WDATA, each accepted byte at cycle t SHALL produce, at cycle t+1:
- fx_wr=1 for exactly one cycle
- fx_data = the accepted byte
- fx_waddr = base + i, where i is the data byte index from 0
REQ-025 After the Nth write SHALL return to IDLE.
REQ-026 In RREQ SHALL drive fx_rd=1 for one cycle with fx_raddr = base + i.
REQ-027 In RWAIT SHALL wait RD_LAT cycles after the fx_rd cycle, then capture fx_q into tx_data.
REQ-028 In RSEND SHALL hold tx_vld=1 and tx_data stable until tx_rdy is high, then:
- increment the address and the index
- go to RREQ, or to IDLE after the Nth byte
REQ-029 Address increment SHALL be modulo 2^22 (22'h3FFFFF + 1 = 22'h000000); the index counter SHALL be 9 bits.
REQ-030 fx_wr and fx_rd SHALL never be high in the same cycle; no strobe SHALL occur outside WDATA and RREQ.
REQ-031 fx_waddr, fx_data and fx_raddr SHALL hold their last values between strobes.
REQ-032 In CMD through WDATA, TIMEOUT consecutive cycles without an accepted byte SHALL pulse err and return to IDLE; writes already issued are not undone.
REQ-033 The read phase SHALL NOT time out; tx back-pressure may stall indefinitely.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On rst_n low, SHALL asynchronously force:
- state IDLE
- rx_rdy=0, tx_vld=0, fx_wr=0, fx_rd=0, err=0
- tx_data=0, fx_data=0, fx_waddr=0, fx_raddr=0
- all counters 0
REQ-036 On the first cycle after rst_n is released, SHALL set rx_rdy=1.
REQ-037 Reset mid-packet SHALL abandon the packet; no strobe SHALL occur in the cycle after release.

Verification
REQ-038 Write: A5 01 00 12 34 02 AA BB -> fx_wr pulses with waddr 0x001234 / data AA, then 0x001235 / BB, one cycle after each byte is accepted; err stays 0.
REQ-039 Read with RD_LAT=1, responder returns addr[7:0]: A5 02 3F FF FF 03 -> fx_raddr 3FFFFF, 000000, 000001; tx bytes FF, 00, 01.
REQ-040 Back-pressure: during REQ-039, hold tx_rdy=0 for 10 cycles -> tx_vld and tx_data stable; no further fx_rd until accepted.
REQ-041 Errors: bytes 00 11 then A5 07 -> no err on 00/11; err pulses once after 07; a following valid packet executes normally.
REQ-042 Timeout (TIMEOUT=20): A5 01 00 00 10 04 C1, then stall rx -> exactly 1 write, err pulse 20 cycles after C1, rx_rdy high in IDLE.
REQ-043 LEN=00 write of 256 bytes -> 256 fx_wr pulses, final waddr = base + 0xFF; then reset mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/fx_master.sv
// fx_master: byte-stream packet parser driving an fx-style memory port.
// Write packets stream data to fx_wr; read packets stream fx_q back out on tx.
module fx_master #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          RD_LAT    = 1,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic [21:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic [21:0] fx_raddr,
  output logic        fx_rd,
  input  logic [7:0]  fx_q,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADR2, S_ADR1, S_ADR0,
    S_LEN, S_WDATA, S_RREQ, S_RWAIT, S_RSEND
  } state_t;

  localparam logic [2:0]  LAT    = RD_LAT[2:0];
  localparam logic [15:0] TMO_M1 = TIMEOUT - 16'd1;

  state_t      state_q;
  logic        rx_rdy_q, tx_vld_q, fx_wr_q, fx_rd_q, err_q;
  logic [7:0]  tx_data_q, fx_data_q, len_q;
  logic [21:0] fx_waddr_q, fx_raddr_q, addr_q;
  logic [8:0]  idx_q;
  logic [15:0] tcnt_q;
  logic [2:0]  wcnt_q;
  logic        cmd_rd_q;

  logic        acc, in_rx, last, tmo;
  logic [8:0]  idx_d, n_cnt;
  logic [21:0] addr_d;

  assign acc    = rx_vld & rx_rdy_q;
  assign in_rx  = (state_q != S_IDLE) & (state_q <= S_WDATA);
  assign idx_d  = idx_q + 9'd1;
  assign addr_d = addr_q + 22'd1;
  assign n_cnt  = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
  assign last   = (idx_d == n_cnt);
  assign tmo    = (tcnt_q == TMO_M1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_rdy_q   <= 1'b0;
      tx_vld_q   <= 1'b0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      fx_data_q  <= '0;
      fx_waddr_q <= '0;
      fx_raddr_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      wcnt_q     <= '0;
      cmd_rd_q   <= 1'b0;
    end else begin
      fx_wr_q <= 1'b0;
      fx_rd_q <= 1'b0;
      err_q   <= 1'b0;
      // Idle watchdog only while a packet header/payload is in flight
      if (in_rx) begin
        if (acc) begin
          tcnt_q <= '0;
        end else if (tmo) begin
          err_q   <= 1'b1;
          state_q <= S_IDLE;
          tcnt_q  <= '0;
        end else begin
          tcnt_q <= tcnt_q + 16'd1;
        end
      end
      unique case (state_q)
        S_IDLE: begin
          rx_rdy_q <= 1'b1;
          tcnt_q   <= '0;
          if (acc && rx_data == SYNC_BYTE)
            state_q <= S_CMD;
        end
        S_CMD: if (acc) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            cmd_rd_q <= (rx_data == 8'h02);
            state_q  <= S_ADR2;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_ADR2: if (acc) begin
          addr_q[21:16] <= rx_data[5:0];
          state_q       <= S_ADR1;
        end
        S_ADR1: if (acc) begin
          addr_q[15:8] <= rx_data;
          state_q      <= S_ADR0;
        end
        S_ADR0: if (acc) begin
          addr_q[7:0] <= rx_data;
          state_q     <= S_LEN;
        end
        S_LEN: if (acc) begin
          len_q <= rx_data;
          idx_q <= '0;
          if (cmd_rd_q) begin
            rx_rdy_q   <= 1'b0;
            fx_rd_q    <= 1'b1;
            fx_raddr_q <= addr_q;
            state_q    <= S_RREQ;
          end else begin
            state_q <= S_WDATA;
          end
        end
        S_WDATA: if (acc) begin
          fx_wr_q    <= 1'b1;
          fx_data_q  <= rx_data;
          fx_waddr_q <= addr_q;
          addr_q     <= addr_d;
          idx_q      <= idx_d;
          if (last)
            state_q <= S_IDLE;
        end
        S_RREQ: begin
          wcnt_q  <= 3'd1;
          state_q <= S_RWAIT;
        end
        S_RWAIT: begin
          if (wcnt_q == LAT) begin
            tx_data_q <= fx_q;
            tx_vld_q  <= 1'b1;
            state_q   <= S_RSEND;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        S_RSEND: if (tx_rdy) begin
          tx_vld_q <= 1'b0;
          idx_q    <= idx_d;
          addr_q   <= addr_d;
          if (last) begin
            rx_rdy_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            fx_rd_q    <= 1'b1;
            fx_raddr_q <= addr_d;
            state_q    <= S_RREQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_rdy   = rx_rdy_q;
  assign tx_data  = tx_data_q;
  assign tx_vld   = tx_vld_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_wr    = fx_wr_q;
  assign fx_data  = fx_data_q;
  assign fx_raddr = fx_raddr_q;
  assign fx_rd    = fx_rd_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fx_master.sv
// tb_fx_master: directed packets against a packet-level scoreboard model
// of fx_master, plus literal expectations for the documented scenarios.
module tb_fx_master;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int LAT = 1;
  localparam int TMO = 20;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic        rx_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b1;
  logic [21:0] fx_waddr, fx_raddr;
  logic        fx_wr, fx_rd;
  logic [7:0]  fx_data;
  logic [7:0]  fx_q = 8'h00;
  logic        err;

  fx_master #(
    .SYNC_BYTE(SYNC), .RD_LAT(LAT), .TIMEOUT(16'(TMO))
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q),
    .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  // Responder: returns the low address byte one cycle after fx_rd.
  always @(posedge clk_sys) if (fx_rd) fx_q <= fx_raddr[7:0];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Packet-level model: pos = bytes of current packet consumed,
  // ph = read progress (0 none, 1 strobe due, 2 latency, 3 offering byte).
  int pos = 0, idle = 0, n = 0, idx = 0, rd_i = 0, ph = 0, wcnt = 0;
  logic [7:0]  cmd = 8'h00, m_wd = 8'h00, m_tx = 8'h00;
  logic [21:0] base = '0, m_wa = '0, m_ra = '0;
  bit e_wr = 0, e_err = 0, after_rst = 1, acc, hs;
  int cyc = 0, last_acc = 0, err_cyc = 0, errcnt = 0;
  logic [29:0] wlog[$];
  logic [21:0] rlog[$];
  logic [7:0]  txlog[$];

  always @(negedge clk_sys) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ctl", {rx_rdy, tx_vld, fx_wr, fx_rd, err}, 64'd0);
      chk("rst_data", {tx_data, fx_data}, 64'd0);
      chk("rst_addr", {fx_waddr, fx_raddr}, 64'd0);
      pos = 0; idle = 0; ph = 0; e_wr = 0; e_err = 0;
      m_wa = '0; m_wd = '0; m_ra = '0; after_rst = 1;
    end else begin
      chk("rx_rdy", rx_rdy, 64'(!after_rst && ph == 0));
      chk("fx_wr", fx_wr, 64'(e_wr));
      chk("fx_waddr", fx_waddr, 64'(m_wa));
      chk("fx_data", fx_data, 64'(m_wd));
      chk("fx_rd", fx_rd, 64'(ph == 1));
      chk("fx_raddr", fx_raddr, 64'(m_ra));
      chk("tx_vld", tx_vld, 64'(ph == 3));
      if (ph == 3) chk("tx_data", tx_data, 64'(m_tx));
      chk("err", err, 64'(e_err));
      if (fx_wr) wlog.push_back({fx_waddr, fx_data});
      if (fx_rd) rlog.push_back(fx_raddr);
      if (tx_vld && tx_rdy) txlog.push_back(tx_data);
      if (err) begin errcnt++; err_cyc = cyc; end

      acc = rx_vld && !after_rst && ph == 0;
      hs = (ph == 3) && tx_rdy;
      e_wr = 0; e_err = 0; after_rst = 0;
      if (acc) last_acc = cyc;
      case (ph)
        0: if (acc) begin
          idle = 0;
          case (pos)
            0: if (rx_data == SYNC) pos = 1;
            1: if (rx_data == 8'h01 || rx_data == 8'h02) begin
                 cmd = rx_data; pos = 2;
               end else begin
                 e_err = 1; pos = 0;
               end
            2: begin base[21:16] = rx_data[5:0]; pos = 3; end
            3: begin base[15:8] = rx_data; pos = 4; end
            4: begin base[7:0] = rx_data; pos = 5; end
            5: begin
                 n = (rx_data == 8'h00) ? 256 : int'(rx_data);
                 idx = 0; rd_i = 0;
                 if (cmd == 8'h01) pos = 6;
                 else begin pos = 0; ph = 1; m_ra = base; end
               end
            default: begin
                 e_wr = 1; m_wa = base + 22'(idx); m_wd = rx_data;
                 idx++;
                 if (idx == n) pos = 0;
               end
          endcase
        end else if (pos != 0) begin
          idle++;
          if (idle == TMO) begin e_err = 1; pos = 0; idle = 0; end
        end
        1: begin ph = 2; wcnt = LAT; end
        2: begin
          wcnt--;
          if (wcnt == 0) begin ph = 3; m_tx = m_ra[7:0]; end
        end
        default: if (hs) begin
          rd_i++;
          if (rd_i == n) ph = 0;
          else begin m_ra = m_ra + 22'd1; ph = 1; end
        end
      endcase
    end
  end

  // Called at posedge+2; returns at posedge+2 after the byte is taken.
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    rx_data = b; rx_vld = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk_sys);
      if (rx_rdy) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(posedge clk_sys); #2;
    rx_vld = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p[$]);
    foreach (p[i]) send(p[i]);
  endtask

  task automatic wait_tx();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_sys);
      if (tx_vld) ok = 1;
    end
    chk("wait_tx_vld", 64'(ok), 64'd1);
  endtask

  task automatic gap(input int c);
    repeat (c) @(posedge clk_sys);
    #2;
  endtask

  task automatic clear_logs();
    wlog.delete(); rlog.delete(); txlog.delete(); errcnt = 0;
  endtask

  initial begin
    logic [7:0] d0;
    int rl;
    bit stable;
    repeat (3) @(posedge clk_sys);
    #2 rst_n = 1'b1;
    @(negedge clk_sys); chk("rdy_first_cycle", rx_rdy, 64'd0);
    @(negedge clk_sys); chk("rdy_after_release", rx_rdy, 64'd1);
    gap(1);

    clear_logs();
    send_pkt('{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB});
    gap(3);
    chk("wr_count", wlog.size(), 64'd2);
    chk("wr0", wlog[0], {22'h001234, 8'hAA});
    chk("wr1", wlog[1], {22'h001235, 8'hBB});
    chk("wr_noerr", errcnt, 64'd0);

    clear_logs();
    tx_rdy = 1'b0;
    send_pkt('{8'hA5, 8'h02, 8'h3F, 8'hFF, 8'hFF, 8'h03});
    wait_tx();
    d0 = tx_data; rl = rlog.size(); stable = 1;
    repeat (10) begin
      @(negedge clk_sys);
      if (!tx_vld || tx_data !== d0 || rlog.size() != rl) stable = 0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    chk("bp_one_rd", rl, 64'd1);
    @(posedge clk_sys); #2 tx_rdy = 1'b1;
    gap(20);
    chk("rd_count", rlog.size(), 64'd3);
    chk("rd0", rlog[0], 64'h3FFFFF);
    chk("rd1", rlog[1], 64'h000000);
    chk("rd2", rlog[2], 64'h000001);
    chk("tx_count", txlog.size(), 64'd3);
    chk("tx0", txlog[0], 64'hFF);
    chk("tx1", txlog[1], 64'h00);
    chk("tx2", txlog[2], 64'h01);

    clear_logs();
    send(8'h00); send(8'h11);
    gap(2);
    chk("junk_noerr", errcnt, 64'd0);
    send(8'hA5); send(8'h07);
    gap(3);
    chk("badcmd_err", errcnt, 64'd1);
    send_pkt('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h20, 8'h01, 8'h5A});
    gap(3);
    chk("post_err_wr", wlog.size(), 64'd1);
    chk("post_err_val", wlog[0], {22'h000020, 8'h5A});
    chk("post_err_cnt", errcnt, 64'd1);

    clear_logs();
    send_pkt('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10, 8'h04, 8'hC1});
    gap(30);
    chk("tmo_writes", wlog.size(), 64'd1);
    chk("tmo_errs", errcnt, 64'd1);
    // err rises on the TMO-th edge after the C1 acceptance edge
    chk("tmo_delay", err_cyc - last_acc, 64'(TMO + 1));
    chk("tmo_rdy", rx_rdy, 64'd1);

    clear_logs();
    send_pkt('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00});
    for (int i = 0; i < 256; i++) send(8'(i));
    gap(3);
    chk("w256_count", wlog.size(), 64'd256);
    chk("w256_first", wlog[0], {22'h000100, 8'h00});
    chk("w256_last", wlog[255], {22'h0001FF, 8'hFF});
    chk("w256_noerr", errcnt, 64'd0);

    tx_rdy = 1'b0;
    send_pkt('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h10, 8'h05});
    wait_tx();
    @(posedge clk_sys); #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {rx_rdy, tx_vld, fx_wr, fx_rd, err}, 64'd0);
    chk("rst_mid_dat", {tx_data, fx_data}, 64'd0);
    chk("rst_mid_adr", {fx_waddr, fx_raddr}, 64'd0);
    @(posedge clk_sys); #2 rst_n = 1'b1; tx_rdy = 1'b1;
    gap(5);
    chk("post_rst_rdy", rx_rdy, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
